// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    // Sequencer phases: waiting, iterating, writing HI/LO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    // Decoder hilo field of the instruction in ID.
    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b10;
    localparam logic [1:0] HILO_LO   = 2'b01;

    // R-type funct codes handled by (or reading from) this unit.
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    // Any non-zero hilo code reads HI/LO; the illegal 11 is treated as a read.
    function automatic logic is_hilo_read(input logic [1:0] hilo);
        return hilo != HILO_NONE;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer datapath on the pair {acc, op}.
// mult: acc = running high half, op = multiplier bits (consumed LSB first),
//       operand = multiplicand magnitude.
// div:  acc = partial remainder, op = dividend shifting out / quotient shifting in,
//       operand = divisor magnitude.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] op_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_trial;
    logic             fits;

    // Trial subtraction: the remainder after subtracting is always below the
    // divisor, so the low WIDTH bits of the wrapped difference are exact.
    assign sum       = {1'b0, acc} + {1'b0, operand};
    assign shifted   = {acc, op[WIDTH-1]};
    assign fits      = shifted >= {1'b0, operand};
    assign rem_trial = shifted[WIDTH-1:0] - operand;

    // Select the add-shift or restore/subtract step.
    always_comb begin
        acc_next = acc;
        op_next  = op;
        if (is_div) begin
            if (fits) begin
                acc_next = rem_trial;
                op_next  = {op[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                op_next  = {op[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (op[0]) begin
                {acc_next, op_next} = {sum, op[WIDTH-1:1]};
            end else begin
                {acc_next, op_next} = {1'b0, acc, op[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed mult/div sequencer owning HI/LO, with pipeline stall control.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [1:0]       hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divzero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] op_reg, op_next;
    logic [WIDTH-1:0] operand_reg, operand_next;
    logic             is_div_reg, is_div_next;
    logic             sign_a_reg, sign_a_next;
    logic             sign_b_reg, sign_b_next;
    logic             divzero_reg, divzero_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   step_acc, step_op;
    logic [2*WIDTH-1:0] product, product_neg;
    logic               div_by_zero;

    // Magnitudes as unsigned; the most negative value maps onto itself,
    // which is also its correct unsigned magnitude.
    assign abs_a       = srca[WIDTH-1] ? -srca : srca;
    assign abs_b       = srcb[WIDTH-1] ? -srcb : srcb;
    assign div_by_zero = is_div && (srcb == '0);
    assign product     = {acc_reg, op_reg};
    assign product_neg = -product;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .op       (op_reg),
        .operand  (operand_reg),
        .acc_next (step_acc),
        .op_next  (step_op)
    );

    // Next-state and datapath updates for accept, iterate and fixup.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        acc_next     = acc_reg;
        op_next      = op_reg;
        operand_next = operand_reg;
        is_div_next  = is_div_reg;
        sign_a_next  = sign_a_reg;
        sign_b_next  = sign_b_reg;
        divzero_next = divzero_reg;
        done_next    = 1'b0;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    is_div_next  = is_div;
                    sign_a_next  = srca[WIDTH-1];
                    sign_b_next  = srcb[WIDTH-1];
                    count_next   = '0;
                    divzero_next = div_by_zero;
                    op_next      = is_div ? abs_a : abs_b;
                    operand_next = is_div ? abs_b : abs_a;
                    if (div_by_zero) begin
                        // Park the raw dividend in acc; it becomes HI unchanged.
                        acc_next   = srca;
                        state_next = FIXUP;
                    end else begin
                        acc_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                acc_next   = step_acc;
                op_next    = step_op;
                count_next = count_reg + CW'(1);
                if (count_reg == LAST) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                state_next = IDLE;
                done_next  = 1'b1;
                if (divzero_reg) begin
                    lo_next = '1;
                    hi_next = acc_reg;
                end else if (is_div_reg) begin
                    // MIN / -1 yields magnitude 2^(W-1), negated back to itself.
                    lo_next = (sign_a_reg ^ sign_b_reg) ? -op_reg : op_reg;
                    hi_next = sign_a_reg ? -acc_reg : acc_reg;
                end else begin
                    {hi_next, lo_next} = (sign_a_reg ^ sign_b_reg) ? product_neg : product;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath, flag and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg   <= '0;
            acc_reg     <= '0;
            op_reg      <= '0;
            operand_reg <= '0;
            is_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            divzero_reg <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            count_reg   <= count_next;
            acc_reg     <= acc_next;
            op_reg      <= op_next;
            operand_reg <= operand_next;
            is_div_reg  <= is_div_next;
            sign_a_reg  <= sign_a_next;
            sign_b_reg  <= sign_b_next;
            divzero_reg <= divzero_next;
            done_reg    <= done_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign done    = done_reg;
    assign divzero = divzero_reg;
    assign busy    = (state_reg != IDLE);
    // Hold the pipeline while an op is pending and EX/ID needs the unit or HI/LO;
    // the IDLE term covers a new op in EX racing an mfhi/mflo in ID.
    assign stall   = (busy && (start || is_hilo_read(hilo_rd)))
                   || ((state_reg == IDLE) && start && is_hilo_read(hilo_rd));

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_div = 1'b0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic [1:0]  hilo_rd = 2'b00;
    logic [31:0] hi, lo;
    logic        busy, stall, done, divzero;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .is_div  (is_div),
        .srca    (srca),
        .srcb    (srcb),
        .hilo_rd (hilo_rd),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .divzero (divzero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // MIPS semantics: signed 64-bit product; truncating division with remainder
    // taking the dividend's sign; divide-by-zero gives LO=all ones, HI=dividend.
    function automatic void model(input logic d, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!d) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Called just after the accepting edge; counts busy cycles until done.
    task automatic wait_done(output int nbusy);
        int guard;
        guard = 0;
        nbusy = 0;
        while (done !== 1'b1 && guard < 100) begin
            if (busy) nbusy++;
            guard++;
            @(posedge clk); #1;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        dz;
        int          nb;
        model(d, a, b, eh, el);
        dz = d && (b == 32'd0);
        @(negedge clk);
        start = 1'b1; is_div = d; srca = a; srcb = b; hilo_rd = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        check("divzero_e0", 64'(divzero), 64'(dz));
        wait_done(nb);
        check("latency", 64'(nb), dz ? 64'd1 : 64'd33);
        check("lo", 64'(lo), 64'(el));
        check("hi", 64'(hi), 64'(eh));
        check("divzero_hold", 64'(divzero), 64'(dz));
        $display("%s a=%h b=%h -> hi=%h lo=%h (exp hi=%h lo=%h)",
                 d ? "div " : "mult", a, b, hi, lo, eh, el);
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        int          nb;
        logic        seen_done;
        logic        d;
        logic [31:0] a, b;
        int          kind;

        // Reset held with a start pending: nothing accepted, outputs cleared.
        start = 1'b1; is_div = 1'b0; srca = 32'd2; srcb = 32'd3;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_hi", 64'(hi), 64'd0);
            check("rst_lo", 64'(lo), 64'd0);
            check("rst_stall", 64'(stall), 64'd0);
            check("rst_done", 64'(done), 64'd0);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_accept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(nb);
        check("rst_op_lo", 64'(lo), 64'd6);
        $display("mult after reset release: lo=%h", lo);
        @(posedge clk); #1;

        // Directed cases.
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b1, 32'd5, 32'd0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000);

        // mult with mflo in ID through the whole op.
        @(negedge clk);
        start = 1'b1; is_div = 1'b0; srca = 32'd3; srcb = 32'd4; hilo_rd = 2'b01;
        #1 check("stall_idle_race", 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 33; k++) begin
            check("stall_rd_busy", 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        check("stall_rd_done", 64'(done), 64'd1);
        check("stall_rd_release", 64'(stall), 64'd0);
        check("stall_rd_lo", 64'(lo), 64'd12);
        check("stall_rd_hi", 64'(hi), 64'd0);
        $display("mult 3*4 with mflo pending: hi=%h lo=%h", hi, lo);
        hilo_rd = 2'b00;
        @(posedge clk); #1;

        // Second start arrives while busy: stalled, accepted in the done cycle.
        @(negedge clk);
        start = 1'b1; is_div = 1'b0; srca = 32'd5; srcb = 32'd6;
        @(posedge clk); #1;
        is_div = 1'b1; srca = 32'd100; srcb = 32'd7;
        for (int k = 0; k < 33; k++) begin
            check("stall_start_busy", 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_stall", 64'(stall), 64'd0);
        check("b2b_lo1", 64'(lo), 64'd30);
        @(posedge clk); #1;
        check("b2b_accept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(nb);
        check("b2b_lo2", 64'(lo), 64'd14);
        check("b2b_hi2", 64'(hi), 64'd2);
        $display("back-to-back mult 5*6 then div 100/7: hi=%h lo=%h", hi, lo);
        @(posedge clk); #1;

        // Reset in the middle of a mult aborts it without touching HI/LO again.
        @(negedge clk);
        start = 1'b1; is_div = 1'b0; srca = 32'd100; srcb = 32'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        $display("reset mid-mult: hi=%h lo=%h busy=%b", hi, lo, busy);

        // Randomized ops, biased toward the interesting boundaries.
        for (int i = 0; i < 40; i++) begin
            d    = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(d, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative signed multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core.
- It accepts mult/div when the decoder's multdiv control reaches EX, then runs a WIDTH-step shift-add or restoring-divide datapath.
- It writes HI/LO and raises stall to hold the pipeline while results are pending, including when mfhi/mflo (decoder hilo) needs them.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH; HI/LO are each WIDTH bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  mult/div valid in EX (decoder multdiv).
- is_div  in  1  1 = div (funct 011010), 0 = mult (funct 011000).
- srca  in  WIDTH  rs operand (multiplicand / dividend).
- srcb  in  WIDTH  rt operand (multiplier / divisor).
- hilo_rd  in  2  decoder hilo of the instruction in ID: 10 = mfhi, 01 = mflo, 00 = none, 11 illegal (treated as a read).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- stall  out  1  freeze PC/IF/ID/EX.
- done  out  1  one-cycle pulse after HI/LO update.
- divzero  out  1  last div had srcb == 0; held until next accepted start.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; hi, lo, counter, internal accumulators = 0; busy = stall = done = divzero = 0. Takes priority over everything and aborts any op in flight; no HI/LO write.
- States: IDLE, CALC, FIXUP; busy = (state != IDLE).
- Accept: start && state==IDLE at edge E0.
  - Latch is_div, sign_a = srca[W-1], sign_b = srcb[W-1].
  - Latch magnitudes |srca|, |srcb| as unsigned; 0x80000000 stays 0x80000000.
  - Clear counter; clear divzero, or set it if is_div && srcb==0.
  - Next state CALC, except divide-by-zero goes straight to FIXUP.
- CALC: one step per edge E1..E_WIDTH; counter 0..WIDTH-1.
  - mult: 2W-bit shift-add on |b| bits, LSB first.
  - div: restoring shift/subtract; the quotient bit is set if the trial remainder is >= 0.
  - At the edge where counter == WIDTH-1, go to FIXUP.
- FIXUP: one cycle. At edge E_(WIDTH+1), write hi/lo, go to IDLE; done = 1 for the following cycle only.
  - mult: {hi,lo} = product, negated (2W-bit two's complement) if sign_a ^ sign_b.
  - div: lo = quotient, negated if sign_a ^ sign_b; hi = remainder, negated if sign_a.
  - Divide-by-zero: lo = all ones, hi = srca as latched (original signed value).
  - 0x80000000 / -1: lo = 0x80000000, hi = 0.
- Latency: normal op 33 busy cycles, HI/LO valid in the cycle after E33 (WIDTH+1). Divzero: 1 busy cycle, valid after E1.
- stall (combinational) = busy && (start || hilo_rd != 00) || (state==IDLE && start && hilo_rd != 00).
  - The last term covers mult in EX with mfhi/mflo in ID in the same cycle. The op is still accepted that cycle.
- Start while busy: not accepted; stall holds the instruction in EX. It is accepted on the first IDLE cycle (the done cycle).
- hi/lo change only at the FIXUP edge. Reads while IDLE with no start see stable values and no stall.

Decomposition:
- Package muldiv_pkg holds:
  - state enum (IDLE, CALC, FIXUP);
  - hilo encodings HILO_HI = 2'b10, HILO_LO = 2'b01;
  - funct constants FN_MULT = 6'b011000, FN_DIV = 6'b011010, FN_MFHI = 6'b010000, FN_MFLO = 6'b010010.
- One sub-module, muldiv_step: a combinational single iteration (mult add-shift or div trial-subtract) on {acc, op} with an is_div select.
- FSM, counter, sign fixup and HI/LO registers stay in muldiv_seq.

Test Plan:
- Reset low 2 cycles with start=1 -> hi=lo=0, busy=0, stall=0; the op is not accepted until reset is released.
- mult srca=7, srcb=0xFFFFFFFD -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses 1 cycle.
- div srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div srca=5, srcb=0 -> divzero=1 after E0, busy 1 cycle, lo=0xFFFFFFFF, hi=5; next accepted mult clears divzero.
- mult 3*4 accepted with hilo_rd=01 in the same and following cycles -> stall=1 through the last busy cycle, 0 in the done cycle; lo=12, hi=0 on read. Second start while busy -> stall=1, accepted in the done cycle.
- Reset pulsed at CALC counter=10 of mult 100*100 -> next cycle busy=0, hi=lo=0, done never pulses.
